// File: rtl/multi_operand_accumulator.sv
// Strobed multi-operand accumulator with sync, edge detect and done flag.
// Optional pb debounce stage when ACCUM_DEBOUNCE_EN is defined.
module multi_operand_accumulator #(
  parameter int WIDTH           = 4,
  parameter int NUM_OPS         = 5,
  parameter int SUM_WIDTH       = 6,
  parameter int CNT_WIDTH       = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pb,
  input  logic [WIDTH-1:0]     y,
  input  logic                 clear,
  output logic [SUM_WIDTH-1:0] sum,
  output logic                 carry,
  output logic [CNT_WIDTH-1:0] op_count,
  output logic                 acc_valid,
  output logic                 done
);

  if (NUM_OPS < 1 || (1 << CNT_WIDTH) <= NUM_OPS ||
      DEBOUNCE_CYCLES < 1 || SUM_WIDTH < WIDTH) begin : g_param_err
    $error("multi_operand_accumulator: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t state, state_nx;

  logic s1, s2, hist, lvl;
  logic strobe, accept, last;
  logic [SUM_WIDTH:0] sum_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pb;
      s2 <= s1;
    end
  end

`ifdef ACCUM_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DBW-1:0] db_cnt;
  logic           db;

  // db follows s2 only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db     <= 1'b0;
      db_cnt <= '0;
    end else if (s2 == db) begin
      db_cnt <= '0;
    end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
      db     <= s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign lvl = db;
`else
  assign lvl = s2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 1'b0;
    else        hist <= lvl;
  end

  assign strobe  = lvl & ~hist;
  assign last    = (op_count == CNT_WIDTH'(NUM_OPS - 1));
  assign sum_ext = {1'b0, sum} + (SUM_WIDTH + 1)'(y);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE, ACCUM: begin
        if (strobe) begin
          accept   = 1'b1;
          state_nx = last ? DONE : ACCUM;
        end
      end
      DONE: ;
      default: state_nx = IDLE;
    endcase
    if (clear) begin
      accept   = 1'b0;
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      carry     <= 1'b0;
      op_count  <= '0;
      acc_valid <= 1'b0;
    end else if (clear) begin
      sum       <= '0;
      carry     <= 1'b0;
      op_count  <= '0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= accept;
      if (accept) begin
        sum      <= sum_ext[SUM_WIDTH-1:0];
        carry    <= carry | sum_ext[SUM_WIDTH];
        op_count <= op_count + 1'b1;
      end
    end
  end

  assign done = (state == DONE);

endmodule

// File: tb/tb_multi_operand_accumulator.sv
// Randomized self-checking bench for multi_operand_accumulator.
// Reference keeps the plain arithmetic total of accepted operands per run.
module tb_multi_operand_accumulator;

  localparam int WIDTH = 4;
  localparam int NOPS  = 5;
  localparam int SW    = 6;
  localparam int CW    = 3;
  localparam int DBC   = 4;
`ifdef ACCUM_DEBOUNCE_EN
  localparam int DB = DBC;
`else
  localparam int DB = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pb = 1'b0;
  logic [WIDTH-1:0] y = '0;
  logic          clear = 1'b0;
  logic [SW-1:0] sum;
  logic          carry;
  logic [CW-1:0] op_count;
  logic          acc_valid;
  logic          done;

  multi_operand_accumulator #(
    .WIDTH(WIDTH), .NUM_OPS(NOPS), .SUM_WIDTH(SW),
    .CNT_WIDTH(CW), .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pb(pb), .y(y),
    .clear(clear), .sum(sum), .carry(carry),
    .op_count(op_count), .acc_valid(acc_valid),
    .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int total = 0;
  int nacc  = 0;
  int nvalid = 0;

  always @(negedge clk) if (acc_valid) nvalid++;

  task automatic check(input string tag,
                       input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sum"}, int'(sum), total % (1 << SW));
    check({tag, ".carry"}, int'(carry),
          int'(total >= (1 << SW)));
    check({tag, ".cnt"}, int'(op_count), nacc);
    check({tag, ".done"}, int'(done), int'(nacc == NOPS));
  endtask

  task automatic press(input int v, input int hi);
    int v0;
    bit exp;
    v0  = nvalid;
    exp = (nacc < NOPS);
    @(negedge clk);
    y  = WIDTH'(v);
    pb = 1'b1;
    repeat (hi + DB) @(negedge clk);
    pb = 1'b0;
    repeat (6 + DB) @(negedge clk);
    if (exp) begin
      total += v;
      nacc++;
    end
    check("valid", nvalid - v0, int'(exp));
    check_all("press");
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total = 0;
    nacc  = 0;
    check_all("clear");
  endtask

  task automatic press_clear(input int v);
    int v0;
    v0 = nvalid;
    @(negedge clk);
    y  = WIDTH'(v);
    pb = 1'b1;
    repeat (2 + DB) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total = 0;
    nacc  = 0;
    check_all("pclr");
    check("pclr.av", int'(acc_valid), 0);
    repeat (DB + 2) @(negedge clk);
    pb = 1'b0;
    repeat (6 + DB) @(negedge clk);
    check("pclr.valid", nvalid - v0, 0);
    check_all("pclr2");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all("reset");
    check("reset.av", int'(acc_valid), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    repeat (5) press(0, 1);
    do_clear();
    repeat (5) press(15, 2);
    do_clear();
    repeat (5) press(10, 1);
    press(3, 1);
    do_clear();
    press(7, 1);
    press(7, 1);
    press_clear(9);
    press(1, 1);
    do_clear();
    repeat (3) press(5, 1);

    @(negedge clk);
    #1 rst_n = 1'b0;
    #2;
    total = 0;
    nacc  = 0;
    check_all("arst");
    check("arst.av", int'(acc_valid), 0);
    #1 rst_n = 1'b1;
    press(2, 1);

    do_clear();
    press(3, 20);

`ifdef ACCUM_DEBOUNCE_EN
    begin
      int v0;
      v0 = nvalid;
      @(negedge clk);
      y  = 4'd9;
      pb = 1'b1;
      repeat (2) @(negedge clk);
      pb = 1'b0;
      repeat (DB + 8) @(negedge clk);
      check("glitch", nvalid - v0, 0);
      check_all("glitch");
    end
`endif

    for (int r = 0; r < 8; r++) begin
      do_clear();
      for (int k = 0; k < NOPS + int'($urandom_range(0, 2)); k++)
        press(int'($urandom_range(0, 15)),
              int'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
